// File: rtl/sc_ulpi_pkg.sv
// sc_ulpi_pkg: shared ULPI types, register map, PHY FSM states and
// register reset values for the ULPI PHY stand-in.
package sc_ulpi_pkg;

  localparam logic [15:0] VENDOR_ID  = 16'h0424;
  localparam logic [15:0] PRODUCT_ID = 16'h0009;

  localparam logic [7:0] FUNC_CTRL_RST = 8'h41;
  localparam logic [7:0] IF_CTRL_RST   = 8'h00;
  localparam logic [7:0] OTG_CTRL_RST  = 8'h06;
  localparam logic [7:0] SCRATCH_RST   = 8'h00;

  typedef enum logic [1:0] {
    ccdSpecial  = 2'b00,
    ccdTransmit = 2'b01,
    ccdRegWrite = 2'b10,
    ccdRegRead  = 2'b11
  } ulpiCCD_e;

  typedef enum logic [1:0] {
    evtNone       = 2'b00,
    evtRxActive   = 2'b01,
    evtHostDiscon = 2'b10,
    evtRxError    = 2'b11
  } utmiEvent_e;

  typedef enum logic [5:0] {
    regVendorIdLow   = 6'h00,
    regVendorIdHigh  = 6'h01,
    regProductIdLow  = 6'h02,
    regProductIdHigh = 6'h03,
    regFuncCtrl      = 6'h04,
    regFuncCtrlSet   = 6'h05,
    regFuncCtrlClr   = 6'h06,
    regIfCtrl        = 6'h07,
    regIfCtrlSet     = 6'h08,
    regIfCtrlClr     = 6'h09,
    regOtgCtrl       = 6'h0A,
    regOtgCtrlSet    = 6'h0B,
    regOtgCtrlClr    = 6'h0C,
    regDebug         = 6'h15,
    regScratch       = 6'h16,
    regScratchSet    = 6'h17,
    regScratchClr    = 6'h18,
    regExtAddr       = 6'h2F
  } ulpiRegMap_e;

  typedef enum logic [3:0] {
    IDLE,
    CMD_ACK,
    EXT_ACK,
    WR_DATA,
    WR_STP,
    RD_TA1,
    RD_DATA,
    RD_TA2,
    RX_TA1,
    RX_CMD,
    RX_TA2
  } ulpiPhyState_e;

  typedef struct packed {
    logic       altInt;
    logic       id;
    utmiEvent_e rxEvent;
    logic [1:0] vbusState;
    logic [1:0] lineState;
  } rxCmd_s;

  typedef struct packed {
    logic       reserved;
    logic       suspendM;
    logic       reset;
    logic [1:0] opMode;
    logic       termSelect;
    logic [1:0] xcvrSelect;
  } funcControl_s;

  typedef struct packed {
    logic useExtVbusInd;
    logic drvVbusExt;
    logic drvVbus;
    logic chrgVbus;
    logic dischrgVbus;
    logic dmPulldown;
    logic dpPulldown;
    logic idPullup;
  } otgControl_s;

  typedef enum logic [1:0] {
    opWrite = 2'd0,
    opSet   = 2'd1,
    opClr   = 2'd2,
    opNone  = 2'd3
  } regOp_e;

  function automatic logic [7:0] applyOp(
    input logic [7:0] cur,
    input logic [7:0] d,
    input regOp_e     op
  );
    logic [7:0] res;
    case (op)
      opWrite: res = d;
      opSet:   res = cur | d;
      opClr:   res = cur & ~d;
      default: res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sc_ulpi_phy_regfile.sv
// sc_ulpi_phy_regfile: PHY control registers with write/set/clear decode,
// read mux and funcControl reset-bit self-clear.
// Ports: CLK, RST (async high), wrEn/addr/wrData write strobe (8-bit
// address, >= 0x40 unmapped), lineState for the debug register,
// rdData read mux, funcCtrl/ifCtrl/otgCtrl register outputs.
module sc_ulpi_phy_regfile
  import sc_ulpi_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       wrEn,
  input  logic [7:0] addr,
  input  logic [7:0] wrData,
  input  logic [1:0] lineState,
  output logic [7:0] rdData,
  output logic [7:0] funcCtrl,
  output logic [7:0] ifCtrl,
  output logic [7:0] otgCtrl
);

  funcControl_s funcReg;
  otgControl_s  otgReg;
  logic [7:0]   ifReg;
  logic [7:0]   scratchReg;

  logic         inMap;
  logic [5:0]   regAddr;
  regOp_e       op;
  logic         selFunc;
  logic         selIf;
  logic         selOtg;
  logic         selScr;

  assign inMap   = (addr[7:6] == 2'b00);
  assign regAddr = addr[5:0];

  always_comb begin
    op      = opNone;
    selFunc = 1'b0;
    selIf   = 1'b0;
    selOtg  = 1'b0;
    selScr  = 1'b0;
    if (wrEn && inMap) begin
      case (regAddr)
        regFuncCtrl:    begin selFunc = 1'b1; op = opWrite; end
        regFuncCtrlSet: begin selFunc = 1'b1; op = opSet;   end
        regFuncCtrlClr: begin selFunc = 1'b1; op = opClr;   end
        regIfCtrl:      begin selIf   = 1'b1; op = opWrite; end
        regIfCtrlSet:   begin selIf   = 1'b1; op = opSet;   end
        regIfCtrlClr:   begin selIf   = 1'b1; op = opClr;   end
        regOtgCtrl:     begin selOtg  = 1'b1; op = opWrite; end
        regOtgCtrlSet:  begin selOtg  = 1'b1; op = opSet;   end
        regOtgCtrlClr:  begin selOtg  = 1'b1; op = opClr;   end
        regScratch:     begin selScr  = 1'b1; op = opWrite; end
        regScratchSet:  begin selScr  = 1'b1; op = opSet;   end
        regScratchClr:  begin selScr  = 1'b1; op = opClr;   end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      funcReg    <= FUNC_CTRL_RST;
      ifReg      <= IF_CTRL_RST;
      otgReg     <= OTG_CTRL_RST;
      scratchReg <= SCRATCH_RST;
    end else begin
      // a fresh write wins over the pending reset-bit clear
      if (selFunc)
        funcReg <= applyOp(funcReg, wrData, op);
      else if (funcReg.reset)
        funcReg.reset <= 1'b0;
      if (selIf)
        ifReg <= applyOp(ifReg, wrData, op);
      if (selOtg)
        otgReg <= applyOp(otgReg, wrData, op);
      if (selScr)
        scratchReg <= applyOp(scratchReg, wrData, op);
    end
  end

  always_comb begin
    rdData = 8'h00;
    if (inMap) begin
      case (regAddr)
        regVendorIdLow:   rdData = VENDOR_ID[7:0];
        regVendorIdHigh:  rdData = VENDOR_ID[15:8];
        regProductIdLow:  rdData = PRODUCT_ID[7:0];
        regProductIdHigh: rdData = PRODUCT_ID[15:8];
        regFuncCtrl,
        regFuncCtrlSet,
        regFuncCtrlClr:   rdData = funcReg;
        regIfCtrl,
        regIfCtrlSet,
        regIfCtrlClr:     rdData = ifReg;
        regOtgCtrl,
        regOtgCtrlSet,
        regOtgCtrlClr:    rdData = otgReg;
        regDebug:         rdData = {6'b0, lineState};
        regScratch,
        regScratchSet,
        regScratchClr:    rdData = scratchReg;
        default:          rdData = 8'h00;
      endcase
    end
  end

  assign funcCtrl = funcReg;
  assign ifCtrl   = ifReg;
  assign otgCtrl  = otgReg;

endmodule

// File: rtl/sc_ulpi_phy_reg.sv
// sc_ulpi_phy_reg: PHY-side ULPI register responder and RX CMD generator.
// Ports: CLK, RST (async high); ULPI_DATA_I/ULPI_STP from link,
// ULPI_DATA_O/ULPI_DATA_OE/ULPI_DIR/ULPI_NXT to link (all registered);
// LINE_STATE, VBUS_STATE, RX_EVENT, ID, ALT_INT feed the RX CMD byte;
// FUNC_CTRL, IF_CTRL, OTG_CTRL expose the control registers.
// Define SC_ULPI_PHY_EXT_REG_EN to enable the extended-address (EAD) path.
module sc_ulpi_phy_reg
  import sc_ulpi_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] ULPI_DATA_I,
  output logic [7:0] ULPI_DATA_O,
  output logic       ULPI_DATA_OE,
  output logic       ULPI_DIR,
  output logic       ULPI_NXT,
  input  logic       ULPI_STP,
  input  logic [1:0] LINE_STATE,
  input  logic [1:0] VBUS_STATE,
  input  logic [1:0] RX_EVENT,
  input  logic       ID,
  input  logic       ALT_INT,
  output logic [7:0] FUNC_CTRL,
  output logic [7:0] IF_CTRL,
  output logic [7:0] OTG_CTRL
);

  ulpiPhyState_e state;
  rxCmd_s        rxStatus;
  rxCmd_s        rxSnap;
  logic [7:0]    regAddr;
  logic [7:0]    wrData;
  logic          isRead;
  logic [7:0]    rdData;
  logic          wrEn;
  logic          txCmd;
  logic          rxPending;
  logic          extHit;

  assign rxStatus = {ALT_INT, ID, RX_EVENT, VBUS_STATE, LINE_STATE};

  assign txCmd = (ULPI_DATA_I[7:6] == ccdRegWrite) ||
                 (ULPI_DATA_I[7:6] == ccdRegRead);

  // RX CMD only starts on an idle (NOOP) bus
  assign rxPending = (ULPI_DATA_I == 8'h00) &&
                     (rxStatus != rxSnap);

  // commit happens on the edge that samples STP
  assign wrEn = (state == WR_STP) && ULPI_STP;

`ifdef SC_ULPI_PHY_EXT_REG_EN
  assign extHit = (regAddr[5:0] == regExtAddr);
`else
  assign extHit = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      ULPI_DATA_O  <= 8'h00;
      ULPI_DATA_OE <= 1'b0;
      ULPI_DIR     <= 1'b0;
      ULPI_NXT     <= 1'b0;
      rxSnap       <= '0;
      regAddr      <= 8'h00;
      wrData       <= 8'h00;
      isRead       <= 1'b0;
    end else begin
      ULPI_DATA_O  <= 8'h00;
      ULPI_DATA_OE <= 1'b0;
      ULPI_DIR     <= 1'b0;
      ULPI_NXT     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (txCmd) begin
            state    <= CMD_ACK;
            ULPI_NXT <= 1'b1;
            regAddr  <= {2'b00, ULPI_DATA_I[5:0]};
            isRead   <= ULPI_DATA_I[6];
          end else if (rxPending) begin
            state    <= RX_TA1;
            ULPI_DIR <= 1'b1;
            rxSnap   <= rxStatus;
          end
        end
        CMD_ACK: begin
          if (extHit) begin
            state    <= EXT_ACK;
            ULPI_NXT <= 1'b1;
          end else if (isRead) begin
            state    <= RD_TA1;
            ULPI_DIR <= 1'b1;
          end else begin
            state    <= WR_DATA;
            ULPI_NXT <= 1'b1;
          end
        end
`ifdef SC_ULPI_PHY_EXT_REG_EN
        EXT_ACK: begin
          regAddr <= ULPI_DATA_I;
          if (isRead) begin
            state    <= RD_TA1;
            ULPI_DIR <= 1'b1;
          end else begin
            state    <= WR_DATA;
            ULPI_NXT <= 1'b1;
          end
        end
`endif
        WR_DATA: begin
          if (ULPI_STP) begin
            state <= IDLE;
          end else begin
            wrData <= ULPI_DATA_I;
            state  <= WR_STP;
          end
        end
        WR_STP: begin
          if (ULPI_STP)
            state <= IDLE;
        end
        RD_TA1: begin
          state        <= RD_DATA;
          ULPI_DIR     <= 1'b1;
          ULPI_DATA_OE <= 1'b1;
          ULPI_DATA_O  <= rdData;
        end
        RD_DATA: state <= RD_TA2;
        RD_TA2:  state <= IDLE;
        RX_TA1: begin
          state        <= RX_CMD;
          ULPI_DIR     <= 1'b1;
          ULPI_DATA_OE <= 1'b1;
          ULPI_DATA_O  <= rxSnap;
        end
        RX_CMD:  state <= RX_TA2;
        RX_TA2:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sc_ulpi_phy_regfile uRegfile (
    .CLK       (CLK),
    .RST       (RST),
    .wrEn      (wrEn),
    .addr      (regAddr),
    .wrData    (wrData),
    .lineState (LINE_STATE),
    .rdData    (rdData),
    .funcCtrl  (FUNC_CTRL),
    .ifCtrl    (IF_CTRL),
    .otgCtrl   (OTG_CTRL)
  );

endmodule

// File: tb/tb_sc_ulpi_phy_reg.sv
// tb_sc_ulpi_phy_reg: self-checking bench for sc_ulpi_phy_reg.
// Bus bytes seen with DIR&OE are checked against a scoreboard queue.
module tb_sc_ulpi_phy_reg;

  logic       CLK;
  logic       RST;
  logic [7:0] dataI;
  logic       stp;
  logic [1:0] lineState;
  logic [1:0] vbusState;
  logic [1:0] rxEvent;
  logic       id;
  logic       altInt;
  logic [7:0] dataO;
  logic       dataOe;
  logic       dir;
  logic       nxt;
  logic [7:0] funcCtrl;
  logic [7:0] ifCtrl;
  logic [7:0] otgCtrl;

  int         checks;
  int         errors;
  logic [7:0] sbq[$];

  sc_ulpi_phy_reg dut (
    .CLK          (CLK),
    .RST          (RST),
    .ULPI_DATA_I  (dataI),
    .ULPI_DATA_O  (dataO),
    .ULPI_DATA_OE (dataOe),
    .ULPI_DIR     (dir),
    .ULPI_NXT     (nxt),
    .ULPI_STP     (stp),
    .LINE_STATE   (lineState),
    .VBUS_STATE   (vbusState),
    .RX_EVENT     (rxEvent),
    .ID           (id),
    .ALT_INT      (altInt),
    .FUNC_CTRL    (funcCtrl),
    .IF_CTRL      (ifCtrl),
    .OTG_CTRL     (otgCtrl)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_read(input logic [7:0] cmd, input bit ext,
                         input logic [7:0] ead, input logic [7:0] exp);
    logic [7:0] want;
    sbq.push_back(exp);
    dataI = cmd;
    tick();
    checks++;
    if (nxt !== 1'b1 || dir !== 1'b0) begin
      errors++;
      $display("FAIL rd_ack cmd=%h nxt=%b dir=%b want nxt=1 dir=0",
               cmd, nxt, dir);
    end
    tick();
    if (ext) begin
      dataI = ead;
      checks++;
      if (nxt !== 1'b1 || dir !== 1'b0) begin
        errors++;
        $display("FAIL rd_ead cmd=%h nxt=%b dir=%b want nxt=1 dir=0",
                 cmd, nxt, dir);
      end
      tick();
    end
    dataI = 8'h00;
    checks++;
    if (dir !== 1'b1 || dataOe !== 1'b0 || nxt !== 1'b0) begin
      errors++;
      $display("FAIL rd_ta1 cmd=%h dir=%b oe=%b nxt=%b want 1 0 0",
               cmd, dir, dataOe, nxt);
    end
    tick();
    checks++;
    if (dir !== 1'b1 || dataOe !== 1'b1 || nxt !== 1'b0) begin
      errors++;
      $display("FAIL rd_bus cmd=%h dir=%b oe=%b nxt=%b want 1 1 0",
               cmd, dir, dataOe, nxt);
    end
    want = sbq.pop_front();
    checks++;
    if (dataO !== want) begin
      errors++;
      $display("FAIL rd_data cmd=%h ead=%h got %h want %h",
               cmd, ead, dataO, want);
    end
    tick();
    checks++;
    if (dir !== 1'b0 || dataOe !== 1'b0) begin
      errors++;
      $display("FAIL rd_ta2 cmd=%h dir=%b oe=%b want 0 0",
               cmd, dir, dataOe);
    end
    tick();
  endtask

  task automatic do_write(input logic [7:0] cmd, input bit ext,
                          input logic [7:0] ead, input logic [7:0] d,
                          input int waitCyc);
    dataI = cmd;
    tick();
    checks++;
    if (nxt !== 1'b1) begin
      errors++;
      $display("FAIL wr_ack cmd=%h nxt=%b want 1", cmd, nxt);
    end
    tick();
    if (ext) begin
      dataI = ead;
      checks++;
      if (nxt !== 1'b1) begin
        errors++;
        $display("FAIL wr_ead cmd=%h nxt=%b want 1", cmd, nxt);
      end
      tick();
    end
    dataI = d;
    checks++;
    if (nxt !== 1'b1 || dir !== 1'b0) begin
      errors++;
      $display("FAIL wr_data cmd=%h nxt=%b dir=%b want 1 0",
               cmd, nxt, dir);
    end
    tick();
    dataI = 8'h00;
    checks++;
    if (nxt !== 1'b0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL wr_stp cmd=%h nxt=%b dir=%b want 0 0",
               cmd, nxt, dir);
    end
    repeat (waitCyc) tick();
    stp = 1'b1;
    tick();
    stp = 1'b0;
  endtask

  task automatic do_rx(input logic [7:0] exp, input int expLat,
                       input bit bump);
    int         lat;
    bit         found;
    logic [7:0] want;
    sbq.push_back(exp);
    lat = 0;
    found = 1'b0;
    for (int c = 1; c <= 8 && !found; c++) begin
      tick();
      if (dir === 1'b1) begin
        found = 1'b1;
        lat = c;
      end
    end
    checks++;
    if (!found || lat != expLat) begin
      errors++;
      $display("FAIL rx_latency exp=%h got %0d want %0d", exp, lat, expLat);
    end
    if (!found) begin
      void'(sbq.pop_back());
      return;
    end
    if (bump) vbusState = 2'b11;
    checks++;
    if (dataOe !== 1'b0 || nxt !== 1'b0) begin
      errors++;
      $display("FAIL rx_ta1 oe=%b nxt=%b want 0 0", dataOe, nxt);
    end
    tick();
    checks++;
    if (dir !== 1'b1 || dataOe !== 1'b1 || nxt !== 1'b0) begin
      errors++;
      $display("FAIL rx_bus dir=%b oe=%b nxt=%b want 1 1 0",
               dir, dataOe, nxt);
    end
    want = sbq.pop_front();
    checks++;
    if (dataO !== want) begin
      errors++;
      $display("FAIL rx_data got %h want %h", dataO, want);
    end
    tick();
    checks++;
    if (dir !== 1'b0 || dataOe !== 1'b0) begin
      errors++;
      $display("FAIL rx_ta2 dir=%b oe=%b want 0 0", dir, dataOe);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({dir, dataOe, nxt} !== 3'b000 || dataO !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus got %b/%h want 000/00",
               {dir, dataOe, nxt}, dataO);
    end
    checks++;
    if (funcCtrl !== 8'h41) begin
      errors++;
      $display("FAIL reset_func got %h want 41", funcCtrl);
    end
    checks++;
    if (ifCtrl !== 8'h00) begin
      errors++;
      $display("FAIL reset_if got %h want 00", ifCtrl);
    end
    checks++;
    if (otgCtrl !== 8'h06) begin
      errors++;
      $display("FAIL reset_otg got %h want 06", otgCtrl);
    end
    RST = 1'b0;
    repeat (3) tick();
    checks++;
    if (dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet dir=%b want 0", dir);
    end
  endtask

  task automatic test_write();
    dataI = 8'h8A;
    tick();
    checks++;
    if (nxt !== 1'b1) begin
      errors++;
      $display("FAIL wr_n1 nxt=%b want 1", nxt);
    end
    tick();
    checks++;
    if (nxt !== 1'b1) begin
      errors++;
      $display("FAIL wr_n2 nxt=%b want 1", nxt);
    end
    dataI = 8'h61;
    tick();
    dataI = 8'h00;
    checks++;
    if (nxt !== 1'b0 || otgCtrl !== 8'h06) begin
      errors++;
      $display("FAIL wr_n3 nxt=%b otg=%h want 0 06", nxt, otgCtrl);
    end
    tick();
    checks++;
    if (otgCtrl !== 8'h06) begin
      errors++;
      $display("FAIL wr_wait otg=%h want 06", otgCtrl);
    end
    stp = 1'b1;
    tick();
    stp = 1'b0;
    checks++;
    if (otgCtrl !== 8'h61) begin
      errors++;
      $display("FAIL wr_commit otg=%h want 61", otgCtrl);
    end
  endtask

  task automatic test_setclr();
    do_write(8'h85, 1'b0, 8'h00, 8'h20, 0);
    checks++;
    if (funcCtrl !== 8'h61) begin
      errors++;
      $display("FAIL func_set got %h want 61", funcCtrl);
    end
    tick();
    checks++;
    if (funcCtrl !== 8'h41) begin
      errors++;
      $display("FAIL func_selfclr got %h want 41", funcCtrl);
    end
    do_write(8'h8C, 1'b0, 8'h00, 8'h01, 0);
    checks++;
    if (otgCtrl !== 8'h60) begin
      errors++;
      $display("FAIL otg_clr got %h want 60", otgCtrl);
    end
    do_write(8'h8B, 1'b0, 8'h00, 8'h80, 2);
    checks++;
    if (otgCtrl !== 8'hE0) begin
      errors++;
      $display("FAIL otg_set got %h want E0", otgCtrl);
    end
    do_write(8'h87, 1'b0, 8'h00, 8'h5A, 0);
    do_write(8'h89, 1'b0, 8'h00, 8'h0A, 0);
    checks++;
    if (ifCtrl !== 8'h50) begin
      errors++;
      $display("FAIL if_wr_clr got %h want 50", ifCtrl);
    end
    do_write(8'h95, 1'b0, 8'h00, 8'hFF, 0);
    checks++;
    if ({funcCtrl, ifCtrl, otgCtrl} !== 24'h4150E0) begin
      errors++;
      $display("FAIL unmapped_wr got %h want 4150e0",
               {funcCtrl, ifCtrl, otgCtrl});
    end
  endtask

  task automatic test_read();
    do_read(8'hC1, 1'b0, 8'h00, 8'h04);
    do_read(8'hC0, 1'b0, 8'h00, 8'h24);
    do_read(8'hC2, 1'b0, 8'h00, 8'h09);
    do_read(8'hC3, 1'b0, 8'h00, 8'h00);
    do_read(8'hC4, 1'b0, 8'h00, 8'h41);
    do_read(8'hC8, 1'b0, 8'h00, 8'h50);
    do_read(8'hCC, 1'b0, 8'h00, 8'hE0);
    do_read(8'hD6, 1'b0, 8'h00, 8'h00);
    do_read(8'hD5, 1'b0, 8'h00, 8'h00);
    do_read(8'hD0, 1'b0, 8'h00, 8'h00);
    do_write(8'h96, 1'b0, 8'h00, 8'hA5, 0);
    do_write(8'h97, 1'b0, 8'h00, 8'h0F, 0);
    do_read(8'hD8, 1'b0, 8'h00, 8'hAF);
    do_write(8'h98, 1'b0, 8'h00, 8'h0A, 0);
    do_read(8'hD6, 1'b0, 8'h00, 8'hA5);
  endtask

  task automatic test_ext();
`ifdef SC_ULPI_PHY_EXT_REG_EN
    do_read(8'hEF, 1'b1, 8'h16, 8'hA5);
    do_read(8'hEF, 1'b1, 8'h56, 8'h00);
    do_read(8'hEF, 1'b1, 8'h01, 8'h04);
    do_write(8'hAF, 1'b1, 8'h16, 8'h3C, 0);
    do_read(8'hD6, 1'b0, 8'h00, 8'h3C);
    do_write(8'hAF, 1'b1, 8'h47, 8'hFF, 0);
    do_read(8'hD6, 1'b0, 8'h00, 8'h3C);
`else
    do_read(8'hEF, 1'b0, 8'h00, 8'h00);
    do_write(8'hAF, 1'b0, 8'h00, 8'hFF, 0);
    do_read(8'hD6, 1'b0, 8'h00, 8'hA5);
`endif
  endtask

  task automatic test_ignore();
    int busy;
    busy = 0;
    dataI = 8'h41;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (nxt !== 1'b0 || dir !== 1'b0) busy++;
    end
    dataI = 8'h05;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (nxt !== 1'b0 || dir !== 1'b0) busy++;
    end
    dataI = 8'h00;
    checks++;
    if (busy != 0) begin
      errors++;
      $display("FAIL ignore_ccd busy cycles %0d want 0", busy);
    end
    tick();
  endtask

  task automatic test_rxcmd();
    int busy;
    lineState = 2'b01;
    do_rx(8'h01, 1, 1'b1);
    do_rx(8'h0D, 2, 1'b0);
    busy = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dir !== 1'b0) busy++;
    end
    checks++;
    if (busy != 0) begin
      errors++;
      $display("FAIL rx_quiet dir cycles %0d want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    lineState = 2'b00;
    vbusState = 2'b00;
    do_read(8'hC0, 1'b0, 8'h00, 8'h24);
    do_rx(8'h00, 1, 1'b0);
    tick();
  endtask

  task automatic test_rst_mid();
    int busy;
    dataI = 8'h8A;
    tick();
    tick();
    dataI = 8'h33;
    tick();
    dataI = 8'h00;
    #2 RST = 1'b1;
    #1;
    checks++;
    if (otgCtrl !== 8'h06 || {dir, dataOe, nxt} !== 3'b000) begin
      errors++;
      $display("FAIL rst_wr otg=%h bus=%b want 06 000",
               otgCtrl, {dir, dataOe, nxt});
    end
    stp = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    stp = 1'b0;
    tick();
    checks++;
    if (otgCtrl !== 8'h06) begin
      errors++;
      $display("FAIL rst_discard otg=%h want 06", otgCtrl);
    end
    dataI = 8'hC1;
    tick();
    tick();
    dataI = 8'h00;
    tick();
    checks++;
    if (dataOe !== 1'b1 || dataO !== 8'h04) begin
      errors++;
      $display("FAIL rst_rd_pre oe=%b data=%h want 1 04", dataOe, dataO);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({dir, dataOe, nxt} !== 3'b000 || dataO !== 8'h00) begin
      errors++;
      $display("FAIL rst_rd bus=%b data=%h want 000 00",
               {dir, dataOe, nxt}, dataO);
    end
    id = 1'b1;
    tick();
    RST = 1'b0;
    do_rx(8'h40, 1, 1'b0);
    busy = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dir !== 1'b0) busy++;
    end
    checks++;
    if (busy != 0) begin
      errors++;
      $display("FAIL rst_rx_once dir cycles %0d want 0", busy);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    RST       = 1'b1;
    dataI     = 8'h00;
    stp       = 1'b0;
    lineState = 2'b00;
    vbusState = 2'b00;
    rxEvent   = 2'b00;
    id        = 1'b0;
    altInt    = 1'b0;
    test_reset();
    test_write();
    test_setclr();
    test_read();
    test_ext();
    test_ignore();
    test_rxcmd();
    test_back_to_back();
    test_rst_mid();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
